// File: rtl/hdd_pkg.sv
// Shared types and constants for the ProDOS HDD sector server.
// State encoding, block geometry and the latched request record.
package hdd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } hdd_state_e;

  localparam int HDD_BLOCK_BYTES = 512;
  localparam int HDD_BLOCK_SHIFT = 9;

  typedef struct packed {
    logic        wr;
    logic [15:0] sector;
  } hdd_req_t;

endpackage

// File: rtl/hdd_req_edge.sv
// Request front end: edge detect on the card read/write levels, read priority,
// a 1-deep pending slot, and a drop pulse when an edge arrives with the slot full.
module hdd_req_edge
  import hdd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hdd_read,
  input  logic        hdd_write,
  input  logic [15:0] sector,
  input  logic        idle,
  output logic        req_vld,
  output hdd_req_t    req,
  output logic        drop
);

  logic     rd_prev_q, rd_prev_d;
  logic     wr_prev_q, wr_prev_d;
  logic     pend_vld_q, pend_vld_d;
  hdd_req_t pend_q, pend_d;
  logic     rd_edge, wr_edge, new_vld;
  hdd_req_t new_req;

  always_comb begin
    rd_prev_d  = hdd_read;
    wr_prev_d  = hdd_write;
    rd_edge    = hdd_read & ~rd_prev_q;
    wr_edge    = hdd_write & ~wr_prev_q;
    new_vld    = rd_edge | wr_edge;
    new_req    = '{wr: ~rd_edge, sector: sector};
    // A waiting request is older than a fresh edge, so it is served first.
    req_vld    = idle & (pend_vld_q | new_vld);
    req        = pend_vld_q ? pend_q : new_req;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    drop       = 1'b0;
    if (idle) begin
      if (pend_vld_q) begin
        pend_vld_d = new_vld;
        pend_d     = new_req;
      end
    end else if (new_vld) begin
      if (pend_vld_q) begin
        drop = 1'b1;
      end else begin
        pend_vld_d = 1'b1;
        pend_d     = new_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_prev_q  <= 1'b0;
      wr_prev_q  <= 1'b0;
      pend_vld_q <= 1'b0;
    end else begin
      rd_prev_q  <= rd_prev_d;
      wr_prev_q  <= wr_prev_d;
      pend_vld_q <= pend_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_q <= pend_d;
  end

endmodule

// File: rtl/hdd_sector_server.sv
// Storage-side responder for the ProDOS HDD card: validates block requests,
// runs the sd_rd/sd_wr/sd_ack handshake and steers bytes to the card buffer.
module hdd_sector_server
  import hdd_pkg::*;
#(
  parameter int TIMEOUT_BITS = 24
) (
  input  logic        CLK_14M,
  input  logic        RESET,
  input  logic        hdd_read,
  input  logic        hdd_write,
  input  logic [15:0] sector,
  output logic        hdd_mounted,
  output logic        hdd_protect,
  output logic [8:0]  ram_addr,
  output logic [7:0]  ram_di,
  output logic        ram_we,
  input  logic [7:0]  ram_do,
  output logic        hdd_busy,
  output logic        hdd_done,
  output logic        hdd_error,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic [63:0] img_size,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  output logic [7:0]  sd_buff_din,
  input  logic        sd_buff_wr
);

  localparam logic [TIMEOUT_BITS-1:0] WD_LAST = '1;
  // Trip one count early so the cycle the counter would reach WD_LAST is the exit cycle.
  localparam logic [TIMEOUT_BITS-1:0] WD_TRIP = ~TIMEOUT_BITS'(1);

  hdd_state_e              state_q, state_d;
  logic [TIMEOUT_BITS-1:0] wd_q, wd_d;
  logic                    mounted_q, mounted_d;
  logic                    protect_q, protect_d;
  logic [31:0]             blocks_q, blocks_d;
  logic                    error_q, error_d;
  logic [15:0]             lba_q, lba_d;
  logic                    wr_q, wr_d;

  logic     req_vld, drop, req_ok, wd_hit, xfer_win;
  hdd_req_t req;

  hdd_req_edge u_req_edge (
    .clk       (CLK_14M),
    .rst       (RESET),
    .hdd_read  (hdd_read),
    .hdd_write (hdd_write),
    .sector    (sector),
    .idle      (state_q == ST_IDLE),
    .req_vld   (req_vld),
    .req       (req),
    .drop      (drop)
  );

  always_comb begin
    req_ok    = mounted_q & ({16'h0, req.sector} < blocks_q) & ~(req.wr & protect_q);
    wd_hit    = (wd_q == WD_TRIP);
    state_d   = state_q;
    wd_d      = (wd_q == WD_LAST) ? wd_q : wd_q + TIMEOUT_BITS'(1);
    mounted_d = mounted_q;
    protect_d = protect_q;
    blocks_d  = blocks_q;
    error_d   = error_q;
    lba_d     = lba_q;
    wr_d      = wr_q;
    if (img_mounted) begin
      mounted_d = |img_size;
      protect_d = img_readonly;
      blocks_d  = img_size[HDD_BLOCK_SHIFT +: 32];
    end
    case (state_q)
      ST_IDLE: begin
        if (req_vld) begin
          if (req_ok) begin
            state_d = ST_REQ;
            wd_d    = '0;
            error_d = 1'b0;
            lba_d   = req.sector;
            wr_d    = req.wr;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (sd_ack) begin
          state_d = ST_XFER;
          wd_d    = '0;
        end else if (wd_hit) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end
      end
      ST_XFER: begin
        if (!sd_ack) begin
          state_d = ST_DONE;
        end else if (wd_hit) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (drop) error_d = 1'b1;
  end

  always_ff @(posedge CLK_14M) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      wd_q      <= '0;
      mounted_q <= 1'b0;
      protect_q <= 1'b0;
      blocks_q  <= '0;
      error_q   <= 1'b0;
      lba_q     <= '0;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      mounted_q <= mounted_d;
      protect_q <= protect_d;
      blocks_q  <= blocks_d;
      error_q   <= error_d;
      lba_q     <= lba_d;
      wr_q      <= wr_d;
    end
  end

  // Byte steering is only live inside the host's ack window of a transfer.
  always_comb begin
    xfer_win    = (state_q == ST_XFER) & sd_ack;
    ram_addr    = xfer_win ? sd_buff_addr : 9'd0;
    ram_we      = xfer_win & ~wr_q & sd_buff_wr;
    ram_di      = (xfer_win & ~wr_q) ? sd_buff_dout : 8'd0;
    sd_buff_din = (xfer_win & wr_q) ? ram_do : 8'd0;
    hdd_busy    = (state_q == ST_REQ) | (state_q == ST_XFER);
    hdd_done    = (state_q == ST_DONE);
    sd_rd       = (state_q == ST_REQ) & ~wr_q;
    sd_wr       = (state_q == ST_REQ) & wr_q;
    sd_lba      = {16'h0, lba_q};
    hdd_error   = error_q;
    hdd_mounted = mounted_q;
    hdd_protect = protect_q;
  end

endmodule

// File: tb/tb_hdd_sector_server.sv
// Bench for hdd_sector_server: host handshake, byte steering, validation,
// pending slot, watchdog (separate 4-bit instance) and reset behaviour.
module tb_hdd_sector_server;

  logic        CLK_14M, RESET;
  logic        hdd_read, hdd_write;
  logic [15:0] sector;
  logic        img_mounted, img_readonly;
  logic [63:0] img_size;
  logic        sd_ack, sd_ack_w;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  ram_do, w_ram_do;

  logic        hdd_mounted, hdd_protect, ram_we, hdd_busy, hdd_done, hdd_error, sd_rd, sd_wr;
  logic [8:0]  ram_addr;
  logic [7:0]  ram_di, sd_buff_din;
  logic [31:0] sd_lba;

  logic        w_hdd_mounted, w_hdd_protect, w_ram_we, w_hdd_busy, w_hdd_done, w_hdd_error;
  logic        w_sd_rd, w_sd_wr;
  logic [8:0]  w_ram_addr;
  logic [7:0]  w_ram_di, w_sd_buff_din;
  logic [31:0] w_sd_lba;

  int n_checks = 0;
  int n_fail   = 0;
  logic [16:0] exp_q[$];
  logic [7:0]  din_q[$];
  logic [16:0] mon_e;

  hdd_sector_server #(.TIMEOUT_BITS(12)) dut (
    .CLK_14M(CLK_14M), .RESET(RESET), .hdd_read(hdd_read), .hdd_write(hdd_write),
    .sector(sector), .hdd_mounted(hdd_mounted), .hdd_protect(hdd_protect),
    .ram_addr(ram_addr), .ram_di(ram_di), .ram_we(ram_we), .ram_do(ram_do),
    .hdd_busy(hdd_busy), .hdd_done(hdd_done), .hdd_error(hdd_error),
    .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size(img_size),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr)
  );

  hdd_sector_server #(.TIMEOUT_BITS(4)) dut_wd (
    .CLK_14M(CLK_14M), .RESET(RESET), .hdd_read(hdd_read), .hdd_write(hdd_write),
    .sector(sector), .hdd_mounted(w_hdd_mounted), .hdd_protect(w_hdd_protect),
    .ram_addr(w_ram_addr), .ram_di(w_ram_di), .ram_we(w_ram_we), .ram_do(w_ram_do),
    .hdd_busy(w_hdd_busy), .hdd_done(w_hdd_done), .hdd_error(w_hdd_error),
    .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size(img_size),
    .sd_lba(w_sd_lba), .sd_rd(w_sd_rd), .sd_wr(w_sd_wr), .sd_ack(sd_ack_w),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
    .sd_buff_din(w_sd_buff_din), .sd_buff_wr(sd_buff_wr)
  );

  initial CLK_14M = 1'b0;
  always #5 CLK_14M = ~CLK_14M;

  function automatic logic [7:0] rom(input logic [8:0] a);
    return a[7:0] ^ {7'h35, a[8]};
  endfunction

  function automatic logic [7:0] pat(input int k);
    logic [8:0] kk;
    kk = k[8:0];
    return kk[7:0] * 8'd3 + {7'd0, kk[8]} + 8'h11;
  endfunction

  // Card sector buffer: registered read, preloaded contents.
  always @(posedge CLK_14M) begin
    ram_do   <= rom(ram_addr);
    w_ram_do <= rom(w_ram_addr);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK_14M) begin
    if (ram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("ram_we_unexpected", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("ram_wr", {ram_addr, ram_di}, mon_e);
      end
    end
  end

  task automatic tick;
    @(posedge CLK_14M);
    #1;
  endtask

  task automatic mount(input logic [63:0] size, input logic ro);
    img_size = size;
    img_readonly = ro;
    img_mounted = 1'b1;
    tick();
    img_mounted = 1'b0;
  endtask

  task automatic pulse_req(input logic rd, input logic [15:0] sec);
    sector = sec;
    if (rd) hdd_read = 1'b1;
    else hdd_write = 1'b1;
    tick();
    hdd_read = 1'b0;
    hdd_write = 1'b0;
  endtask

  task automatic host_send(input int n);
    sd_ack = 1'b1;
    tick();
    check_eq("req_drop_on_ack", {sd_rd, sd_wr}, 2'b00);
    for (int k = 0; k < n; k++) begin
      sd_buff_addr = k[8:0];
      sd_buff_dout = pat(k);
      sd_buff_wr = 1'b1;
      exp_q.push_back({k[8:0], pat(k)});
      tick();
    end
    sd_buff_wr = 1'b0;
    sd_ack = 1'b0;
    tick();
    check_eq("send_all_written", exp_q.size(), 0);
  endtask

  task automatic host_fetch(input int n);
    sd_ack = 1'b1;
    tick();
    check_eq("req_drop_on_ack", {sd_rd, sd_wr}, 2'b00);
    for (int k = 0; k < n; k++) begin
      sd_buff_addr = k[8:0];
      din_q.push_back(rom(k[8:0]));
      tick();
      check_eq("sd_buff_din", sd_buff_din, din_q.pop_front());
    end
    sd_ack = 1'b0;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    RESET = 1'b1; hdd_read = 0; hdd_write = 0; sector = 0;
    img_mounted = 0; img_readonly = 0; img_size = 0;
    sd_ack = 0; sd_ack_w = 0; sd_buff_addr = 0; sd_buff_dout = 0; sd_buff_wr = 0;
    tick(); tick();
    check_eq("rst_outs", {sd_rd, sd_wr, hdd_busy, hdd_done, hdd_error, hdd_mounted, hdd_protect, ram_we}, 8'h00);
    check_eq("rst_lba", sd_lba, 0);
    RESET = 1'b0;
    tick();

    // Watchdog on the 4-bit instance: host never acks.
    mount(64'h10_0000, 1'b0);
    check_eq("wd_mounted", w_hdd_mounted, 1);
    pulse_req(1'b1, 16'd1);
    n = 0;
    while (w_sd_rd && n < 100) begin
      n++;
      tick();
    end
    check_eq("wd_cycles", n, 15);
    check_eq("wd_error", w_hdd_error, 1);
    check_eq("wd_busy", w_hdd_busy, 0);
    RESET = 1'b1; tick(); RESET = 1'b0; tick();

    // Write to a protected image is refused.
    mount(64'h10_0000, 1'b1);
    check_eq("protect_flag", hdd_protect, 1);
    pulse_req(1'b0, 16'd3);
    check_eq("prot_no_req", {sd_rd, sd_wr, hdd_busy}, 3'b000);
    check_eq("prot_error", hdd_error, 1);
    tick(); tick();
    check_eq("prot_still_idle", {sd_rd, sd_wr, hdd_busy}, 3'b000);

    // Read of block 5 on a 1 MiB read/write image.
    mount(64'h10_0000, 1'b0);
    pulse_req(1'b1, 16'd5);
    check_eq("rd_req", {sd_rd, sd_wr, hdd_busy}, 3'b101);
    check_eq("rd_lba", sd_lba, 32'd5);
    check_eq("rd_err_clr", hdd_error, 0);
    host_send(512);
    check_eq("rd_done", {hdd_done, hdd_busy}, 2'b10);
    tick();
    check_eq("rd_done_pulse", hdd_done, 0);

    // Write of block 7: host pulls the buffer bytes.
    pulse_req(1'b0, 16'h0007);
    check_eq("wr_req", {sd_rd, sd_wr, hdd_busy}, 3'b011);
    check_eq("wr_lba", sd_lba, 32'd7);
    host_fetch(512);
    check_eq("wr_done", {hdd_done, hdd_busy}, 2'b10);
    tick();

    // Block 0x800 is one past the end of a 2048-block image.
    pulse_req(1'b1, 16'h0800);
    check_eq("oob_no_req", {sd_rd, sd_wr, hdd_busy}, 3'b000);
    check_eq("oob_error", hdd_error, 1);
    tick();
    check_eq("oob_busy", hdd_busy, 0);

    // Pending slot: second edge queued, third dropped.
    pulse_req(1'b1, 16'd10);
    check_eq("p1_lba", sd_lba, 32'd10);
    check_eq("p1_err_clr", hdd_error, 0);
    sd_ack = 1'b1;
    tick();
    sector = 16'h07FF; hdd_read = 1'b1; tick(); hdd_read = 1'b0;
    check_eq("p2_queued_err", hdd_error, 0);
    sector = 16'd20; hdd_write = 1'b1; tick(); hdd_write = 1'b0;
    check_eq("p3_drop_err", hdd_error, 1);
    sd_ack = 1'b0;
    tick();
    check_eq("p1_done", hdd_done, 1);
    tick();
    check_eq("p_idle_gap", {sd_rd, hdd_busy}, 2'b00);
    tick();
    check_eq("p2_req", {sd_rd, sd_wr, hdd_busy}, 3'b101);
    check_eq("p2_lba", sd_lba, 32'h7FF);
    check_eq("p2_err_clr", hdd_error, 0);
    host_send(4);
    check_eq("p2_done", hdd_done, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("p3_not_served", {sd_rd, sd_wr, hdd_busy}, 3'b000);
    end

    // Reset in the middle of a transfer.
    pulse_req(1'b1, 16'd2);
    sd_ack = 1'b1;
    tick();
    sd_buff_addr = 9'd3; sd_buff_dout = 8'h77; sd_buff_wr = 1'b1;
    exp_q.push_back({9'd3, 8'h77});
    RESET = 1'b1;
    tick();
    check_eq("mid_rst_outs", {sd_rd, sd_wr, hdd_busy, hdd_done, hdd_error, hdd_mounted, hdd_protect, ram_we}, 8'h00);
    check_eq("mid_rst_lba_addr", {sd_lba, 7'd0, ram_addr}, 48'h0);
    RESET = 1'b0; sd_ack = 1'b0; sd_buff_wr = 1'b0;
    tick();
    mount(64'h10_0000, 1'b0);
    check_eq("remount", hdd_mounted, 1);
    check_eq("remount_idle", {sd_rd, hdd_busy}, 2'b00);
    check_eq("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
